// File: rtl/div_unit.sv
// Sequential 32-bit signed divider: restoring shift/subtract, one step per clock.
// Optional macro DIV_ZERO_EXC_EN: a zero divisor skips the division and raises Div_Zero.
//
// state | meaning
// IDLE  | waiting for Div_Start, operands captured on the start edge
// RUN   | 32 restoring steps, then sign correction and result load
// DONE  | one-cycle Div_Done pulse, results valid
module div_unit (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Div_Start,
    input  logic [31:0] Div_A,
    input  logic [31:0] Div_B,
    output logic [31:0] Div_HIOut,
    output logic [31:0] Div_LOOut,
    output logic        Div_Busy,
    output logic        Div_Done,
    output logic        Div_Zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q;
    logic        fin_q;
    logic [31:0] quo_q;
    logic [31:0] rem_q;
    logic [31:0] dvs_q;
    logic        sign_a_q;
    logic        sign_b_q;
    logic        zero_pend;

    logic        load_en;
    logic        step_en;
    logic        fin_en;
    logic [32:0] rem_shift;
    logic        borrow;
    logic [31:0] diff;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    // 0x80000000 negates to itself, which is exactly its unsigned magnitude
    assign abs_a = Div_A[31] ? -Div_A : Div_A;
    assign abs_b = Div_B[31] ? -Div_B : Div_B;

    assign rem_shift = {rem_q, quo_q[31]};
    assign borrow    = rem_shift < {1'b0, dvs_q};
    assign diff      = rem_shift[31:0] - dvs_q;

    assign q_fix = (sign_a_q ^ sign_b_q) ? -quo_q : quo_q;
    assign r_fix = sign_a_q ? -rem_q : rem_q;

`ifdef DIV_ZERO_EXC_EN
    logic zero_q;
    assign zero_pend = zero_q;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            zero_q <= 1'b0;
        end else if (load_en) begin
            zero_q <= (Div_B == 32'd0);
        end
    end
`else
    assign zero_pend = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        load_en = 1'b0;
        step_en = 1'b0;
        fin_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (Div_Start) begin
                    load_en = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (fin_q || zero_pend) begin
                    fin_en  = 1'b1;
                    state_d = DONE;
                end else begin
                    step_en = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            cnt_q     <= 5'd0;
            fin_q     <= 1'b0;
            quo_q     <= 32'd0;
            rem_q     <= 32'd0;
            dvs_q     <= 32'd0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            Div_HIOut <= 32'd0;
            Div_LOOut <= 32'd0;
            Div_Busy  <= 1'b0;
            Div_Done  <= 1'b0;
            Div_Zero  <= 1'b0;
        end else begin
            state_q  <= state_d;
            Div_Busy <= (state_d == RUN);
            Div_Done <= (state_d == DONE);
            Div_Zero <= (state_d == DONE) && zero_pend;

            if (load_en) begin
                quo_q    <= abs_a;
                rem_q    <= 32'd0;
                dvs_q    <= abs_b;
                sign_a_q <= Div_A[31];
                sign_b_q <= Div_B[31];
                cnt_q    <= 5'd31;
                fin_q    <= 1'b0;
            end

            // Down-counter reaching zero marks the 32nd step; the next edge finalises
            if (step_en) begin
                if (!borrow) begin
                    rem_q <= diff;
                    quo_q <= {quo_q[30:0], 1'b1};
                end else begin
                    rem_q <= rem_shift[31:0];
                    quo_q <= {quo_q[30:0], 1'b0};
                end
                if (cnt_q == 5'd0) begin
                    fin_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q - 5'd1;
                end
            end

            if (fin_en && !zero_pend) begin
                Div_LOOut <= q_fix;
                Div_HIOut <= r_fix;
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Randomized self-checking bench for div_unit against an arithmetic reference model.
// Honours DIV_ZERO_EXC_EN the same way the design does.
module tb_div_unit;

    logic        Clock;
    logic        Reset;
    logic        Div_Start;
    logic [31:0] Div_A;
    logic [31:0] Div_B;
    logic [31:0] Div_HIOut;
    logic [31:0] Div_LOOut;
    logic        Div_Busy;
    logic        Div_Done;
    logic        Div_Zero;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] last_lo = 32'd0;
    logic [31:0] last_hi = 32'd0;

    div_unit dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Div_Start (Div_Start),
        .Div_A     (Div_A),
        .Div_B     (Div_B),
        .Div_HIOut (Div_HIOut),
        .Div_LOOut (Div_LOOut),
        .Div_Busy  (Div_Busy),
        .Div_Done  (Div_Done),
        .Div_Zero  (Div_Zero)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Truncating signed division; a zero divisor counts as positive with quotient magnitude all-ones
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
        longint av, bv, ma, mb, qm, rm, qs, rs;
        av = longint'($signed(a));
        bv = longint'($signed(b));
        ma = (av < 0) ? -av : av;
        mb = (bv < 0) ? -bv : bv;
        if (mb == 0) begin
            qm = 64'h0000_0000_FFFF_FFFF;
            rm = ma;
        end else begin
            qm = ma / mb;
            rm = ma % mb;
        end
        qs = ((av < 0) != (bv < 0)) ? -qm : qm;
        rs = (av < 0) ? -rm : rm;
        q = qs[31:0];
        r = rs[31:0];
    endfunction

    task automatic run_div(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eq, er;
        logic        ez;
        int          exp_cyc;
        int          cyc;
        model(a, b, eq, er);
        ez      = 1'b0;
        exp_cyc = 33;
`ifdef DIV_ZERO_EXC_EN
        if (b == 32'd0) begin
            eq      = last_lo;
            er      = last_hi;
            ez      = 1'b1;
            exp_cyc = 1;
        end
`endif
        @(negedge Clock);
        Div_A     = a;
        Div_B     = b;
        Div_Start = 1'b1;
        @(posedge Clock);
        #1;
        Div_Start = 1'b0;
        Div_A     = $urandom;
        Div_B     = $urandom;
        cyc = 0;
        @(negedge Clock);
        while (!Div_Done && cyc < 40) begin
            if (!ez) chk("busy_run", {31'd0, Div_Busy}, 32'd1);
            @(negedge Clock);
            cyc++;
        end
        chk("done_seen", {31'd0, Div_Done}, 32'd1);
        chk("latency", cyc, exp_cyc);
        chk("busy_done", {31'd0, Div_Busy}, 32'd0);
        chk("lo", Div_LOOut, eq);
        chk("hi", Div_HIOut, er);
        chk("zero", {31'd0, Div_Zero}, {31'd0, ez});
        @(negedge Clock);
        chk("done_clr", {31'd0, Div_Done}, 32'd0);
        chk("zero_clr", {31'd0, Div_Zero}, 32'd0);
        chk("lo_hold", Div_LOOut, eq);
        chk("hi_hold", Div_HIOut, er);
        last_lo = eq;
        last_hi = er;
    endtask

    initial begin
        int          pulses;
        logic [31:0] cap_lo, cap_hi;
        logic [31:0] ra, rb;
        int          sel;

        Reset     = 1'b0;
        Div_Start = 1'b0;
        Div_A     = 32'd0;
        Div_B     = 32'd0;
        #3;
        chk("rst_lo", Div_LOOut, 32'd0);
        chk("rst_hi", Div_HIOut, 32'd0);
        chk("rst_busy", {31'd0, Div_Busy}, 32'd0);
        chk("rst_done", {31'd0, Div_Done}, 32'd0);
        chk("rst_zero", {31'd0, Div_Zero}, 32'd0);
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b1;

        run_div(32'd100, 32'd7);
        run_div(-32'sd100, 32'd7);
        run_div(32'd100, -32'sd7);
        run_div(32'h8000_0000, 32'hFFFF_FFFF);
        run_div(32'd7, 32'd0);
        run_div(-32'sd7, 32'd0);
        run_div(32'd0, 32'd5);
        run_div(32'h8000_0000, 32'h8000_0000);
        run_div(32'h7FFF_FFFF, 32'd1);

        for (int i = 0; i < 24; i++) begin
            sel = $urandom_range(0, 3);
            ra  = $urandom;
            rb  = $urandom;
            case (sel)
                1: rb = ($urandom_range(0, 1) == 1) ? -$urandom_range(1, 20) : $urandom_range(1, 20);
                2: if ($urandom_range(0, 1) == 1) ra = 32'h8000_0000; else rb = 32'h8000_0000;
                3: rb = 32'd0;
                default: ;
            endcase
            run_div(ra, rb);
        end

        // A second start while busy must be ignored entirely
        @(negedge Clock);
        Div_A = 32'd100; Div_B = 32'd7; Div_Start = 1'b1;
        @(posedge Clock);
        #1 Div_Start = 1'b0;
        repeat (4) @(posedge Clock);
        #1 Div_Start = 1'b1; Div_A = 32'd9; Div_B = 32'd3;
        @(posedge Clock);
        #1 Div_Start = 1'b0;
        pulses = 0;
        cap_lo = 32'd0;
        cap_hi = 32'd0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clock);
            if (Div_Done) begin
                pulses++;
                cap_lo = Div_LOOut;
                cap_hi = Div_HIOut;
            end
        end
        chk("restart_pulses", pulses, 1);
        chk("restart_lo", cap_lo, 32'd14);
        chk("restart_hi", cap_hi, 32'd2);
        last_lo = 32'd14;
        last_hi = 32'd2;

        // Reset in the middle of a division aborts it
        @(negedge Clock);
        Div_A = 32'd100; Div_B = 32'd7; Div_Start = 1'b1;
        @(posedge Clock);
        #1 Div_Start = 1'b0;
        repeat (10) @(posedge Clock);
        #2 Reset = 1'b0;
        #1;
        chk("abort_lo", Div_LOOut, 32'd0);
        chk("abort_hi", Div_HIOut, 32'd0);
        chk("abort_busy", {31'd0, Div_Busy}, 32'd0);
        chk("abort_done", {31'd0, Div_Done}, 32'd0);
        chk("abort_zero", {31'd0, Div_Zero}, 32'd0);
        @(negedge Clock);
        Reset = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clock);
            if (Div_Done || Div_Busy) pulses++;
        end
        chk("abort_quiet", pulses, 0);
        last_lo = 32'd0;
        last_hi = 32'd0;
        run_div(32'd9, 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have port Clock  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port Reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL have port Div_Start  input  1  request to begin a division, sampled on the rising edge while in IDLE.
REQ-004 SHALL have port Div_A  input  32  dividend (rs), two's complement.
REQ-005 SHALL have port Div_B  input  32  divisor (rt), two's complement.
REQ-006 SHALL have port Div_HIOut  output  32  remainder, feeds the HI mux.
REQ-007 SHALL have port Div_LOOut  output  32  quotient, feeds the LO mux.
REQ-008 SHALL have port Div_Busy  output  1  high while a division is in progress (RUN state).
REQ-009 SHALL have port Div_Done  output  1  one-cycle pulse; Div_HIOut/Div_LOOut are valid from this cycle.
REQ-010 SHALL have port Div_Zero  output  1  divide-by-zero flag, routed to the control unit's exception logic.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DONE; all outputs registered.
REQ-012 IDLE: on an edge E0 with Div_Start=1, SHALL capture |Div_A|, |Div_B|, sign(Div_A), sign(Div_B) and enter RUN; later operand changes are ignored.
REQ-013 RUN SHALL perform one restoring shift/subtract step per edge, 32 steps on edges E1..E32, tracked by a 5-bit counter.
REQ-014 Edge E33 SHALL apply sign correction, load Div_LOOut/Div_HIOut, enter DONE and set Div_Done=1.
REQ-015 Edge E34 SHALL return to IDLE with Div_Done=0; results SHALL hold until the next completed division or reset.
REQ-016 Quotient SHALL truncate toward zero (negated when the operand signs differ); remainder SHALL take the dividend's sign; magnitude of 0x80000000 SHALL be treated as unsigned 0x80000000.
REQ-017 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000, HI=0x00000000, with no flag raised.
REQ-018 Div_Start SHALL be ignored in RUN and DONE (no restart, no queueing).
REQ-019 Div_Busy SHALL be 1 exactly in RUN (edges E0..E33 window), 0 in IDLE and DONE.
REQ-020 Div_Zero SHALL be a one-cycle pulse coincident with Div_Done, and only when enabled per REQ-024.

Reset
REQ-021 Reset=0 SHALL immediately, independent of Clock, force state IDLE, counter 0, Div_HIOut=0, Div_LOOut=0, Div_Busy=0, Div_Done=0, Div_Zero=0.
REQ-022 Reset asserted mid-RUN SHALL abort the division; no Div_Done SHALL follow release.
REQ-023 After Reset release, the first rising edge with Div_Start=1 SHALL start a fresh operation.

Configuration
REQ-024 With macro DIV_ZERO_EXC_EN defined: Div_B=0 at E0 SHALL skip RUN; E1 SHALL enter DONE with Div_Done=1 and Div_Zero=1, Div_HIOut/Div_LOOut unchanged.
REQ-025 Without DIV_ZERO_EXC_EN: Div_Zero SHALL be tied to 0; Div_B=0 SHALL run the normal 34-cycle sequence, giving quotient magnitude 0xFFFFFFFF (sign-corrected per REQ-016, divisor 0 treated as positive) and remainder = Div_A.

Verification
REQ-026 Div_A=100, Div_B=7, Start at E0 -> Busy E0..E33, Done pulse after E33, LO=0x0000000E, HI=0x00000002.
REQ-027 Div_A=-100, Div_B=7 -> LO=0xFFFFFFF2, HI=0xFFFFFFFE; Div_A=100, Div_B=-7 -> LO=0xFFFFFFF2, HI=0x00000002.
REQ-028 Div_A=0x80000000, Div_B=0xFFFFFFFF -> LO=0x80000000, HI=0x00000000, Div_Zero=0.
REQ-029 Div_A=7, Div_B=0 -> with DIV_ZERO_EXC_EN: Done and Div_Zero high after E1, HI/LO hold previous values; without it: after E33 LO=0xFFFFFFFF, HI=0x00000007, Div_Zero=0.
REQ-030 Start 100/7, then pulse Start with 9/3 at E5 -> second request ignored, result 14 r 2 after E33, exactly one Done pulse.
REQ-031 Start 100/7, drive Reset=0 between E10 and E11 -> outputs 0 immediately, no Done after release; new Start 9/3 -> LO=3, HI=0.
